decoder_scan_n: RTL and testbench



---
 rtl/decoder_scan_n.sv | 128 ++++++++++++
 tb/tb_decoder_scan_n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// decoder_scan_n
//   Registered, parametrised one-hot decoder with an optional auto-scan
//   sequencer.
//   - Manual mode holds a loaded index.
//   - Scan mode walks the index through all outputs. Each index is held
//     for dwell+1 cycles.
//
// Optional feature macro: DECODER_SCAN_EN
//   Defined     : SCAN state, dwell counter, wrap pulse and busy flag.
//   Not defined : mode and dwell are ignored and the block behaves as if
//                 mode = 0. No dwell counter is built. wrap and busy are
//                 tied low.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   output enable (0 forces out to zero)
//   sel        in   [SEL_W]     index to load
//   sel_valid  in   load strobe for sel
//   mode       in   0 = manual hold, 1 = auto-scan
//   dwell      in   [DWELL_W]   cycles per scan step minus one, sampled live
//   out        out  [2^SEL_W]   registered one-hot output
//   idx        out  [SEL_W]     registered current index
//   wrap       out  one-cycle pulse when the scan index wraps N-1 -> 0
//   busy       out  high while in the SCAN state
module decoder_scan_n #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_valid,
  input  logic                    mode,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap,
  output logic                    busy
);

  localparam int N = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [SEL_W-1:0] nxt_idx;
  logic             step;

`ifdef DECODER_SCAN_EN
  logic [DWELL_W-1:0] cnt;
`else
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{mode, dwell};
`endif

  // The next state depends only on en and mode at this edge.
  // A step needs SCAN both now and after the edge. Because of that, the
  // edge that leaves SCAN freezes idx, and the entry edge does not count
  // toward the dwell. The ">=" comparison means that lowering dwell below
  // the running count forces a step on the next edge. A load always wins
  // over a step.
  always_comb begin
    step = 1'b0;
`ifdef DECODER_SCAN_EN
    if (!en)
      nxt_state = IDLE;
    else if (mode)
      nxt_state = SCAN;
    else
      nxt_state = HOLD;
    step = (state == SCAN) && (nxt_state == SCAN) && !sel_valid && (cnt >= dwell);
`else
    nxt_state = en ? HOLD : IDLE;
`endif
    nxt_idx = idx;
    if (sel_valid)
      nxt_idx = sel;
    else if (step)
      nxt_idx = idx + SEL_W'(1);
  end

  // Single state register plus the registered outputs. out is derived from
  // the same next-index value that idx takes. This keeps out either zero
  // or exactly one-hot on every cycle, including the cycles where the
  // mode changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      out   <= '0;
`ifdef DECODER_SCAN_EN
      cnt   <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      if (nxt_state == IDLE)
        out <= '0;
      else
        out <= N'(1) << nxt_idx;
`ifdef DECODER_SCAN_EN
      wrap <= step && (&idx);
      busy <= (nxt_state == SCAN);
      // The counter restarts on a load, on a step, and whenever the block
      // is not scanning across this edge.
      if (sel_valid || step || state != SCAN || nxt_state != SCAN)
        cnt <= '0;
      else
        cnt <= cnt + DWELL_W'(1);
`endif
    end
  end

`ifndef DECODER_SCAN_EN
  assign wrap = 1'b0;
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_scan_n.sv
// tb_decoder_scan_n
//   Self-checking bench for decoder_scan_n with SEL_W = 2.
//   - A cycle-level reference model of the expected outputs is compared
//     against the DUT on every falling edge.
//   - Directed steps add hand-computed literal expectations.
//   - The scan scenarios are compiled only when DECODER_SCAN_EN is defined.
//     The manual-only scenario is compiled only when it is not.
module tb_decoder_scan_n;

  localparam int SEL_W   = 2;
  localparam int DWELL_W = 8;
  localparam int N       = 1 << SEL_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [SEL_W-1:0]   sel = '0;
  logic               sel_valid = 1'b0;
  logic               mode = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [N-1:0]       out;
  logic [SEL_W-1:0]   idx;
  logic               wrap;
  logic               busy;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  decoder_scan_n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .sel_valid(sel_valid),
    .mode(mode), .dwell(dwell), .out(out), .idx(idx), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model of the expected outputs.
  // - m_age counts the cycles already spent on the current index.
  // - A step is due once the age reaches dwell.
  // - Scanning must be active both before and after the edge for a step.
  int     m_idx = 0;
  int     m_age = 0;
  bit     m_was_scan = 1'b0;
  int     m_out = 0;
  bit     m_wrap = 1'b0;
  bit     m_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit scan_on;
    if (!rst_n) begin
      m_idx = 0; m_age = 0; m_was_scan = 0;
      m_out = 0; m_wrap = 0; m_busy = 0;
    end else begin
`ifdef DECODER_SCAN_EN
      scan_on = en && mode;
`else
      scan_on = 1'b0;
`endif
      m_wrap = 1'b0;
      if (sel_valid) begin
        m_idx = int'(sel);
        m_age = 0;
      end else if (m_was_scan && scan_on) begin
        if (m_age >= int'(dwell)) begin
          m_wrap = (m_idx == N - 1);
          m_idx  = (m_idx + 1) % N;
          m_age  = 0;
        end else begin
          m_age = m_age + 1;
        end
      end
      if (!scan_on) m_age = 0;
      m_was_scan = scan_on;
      m_busy     = scan_on;
      m_out      = en ? (1 << m_idx) : 0;
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model_out",  int'(out),  m_out);
      checkOutput("model_idx",  int'(idx),  m_idx);
      checkOutput("model_wrap", int'(wrap), int'(m_wrap));
      checkOutput("model_busy", int'(busy), int'(m_busy));
    end
  end

  // Drive one input vector just after a rising edge, then let n edges pass.
  task automatic applyStimulus(input bit e, input bit m, input int s, input bit sv,
                               input int d, input int n);
    en        = e;
    mode      = m;
    sel       = SEL_W'(s);
    sel_valid = sv;
    dwell     = DWELL_W'(d);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_out", int'(out), 0);
    checkOutput("reset_idx", int'(idx), 0);

    // Manual load of index 2, then hold while sel wanders without a strobe.
    applyStimulus(1, 0, 2, 1, 0, 1);
    checkOutput("load_out", int'(out), 'b0100);
    checkOutput("load_idx", int'(idx), 2);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, i % 4, 0, 0, 1);
    checkOutput("hold_out", int'(out), 'b0100);
    checkOutput("hold_idx", int'(idx), 2);

    // Load index 3 while disabled, then enable.
    applyStimulus(0, 0, 3, 1, 0, 1);
    checkOutput("idle_load_out", int'(out), 0);
    checkOutput("idle_load_idx", int'(idx), 3);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("enable_out", int'(out), 'b1000);

`ifdef DECODER_SCAN_EN
    // Scan with dwell = 2 from idx 0. Each index is held for 3 cycles, and
    // the wrap pulse comes with the return to 0001.
    applyStimulus(1, 0, 0, 1, 2, 1);
    applyStimulus(1, 1, 0, 0, 2, 1);
    for (int c = 0; c < 13; c++) begin
      if (c > 0) applyStimulus(1, 1, 0, 0, 2, 1);
      checkOutput("scan_out",  int'(out),  1 << ((c / 3) % 4));
      checkOutput("scan_wrap", int'(wrap), (c == 12) ? 1 : 0);
      checkOutput("scan_busy", int'(busy), 1);
    end

    // Load on the edge where a step is due (dwell = 3).
    applyStimulus(1, 1, 0, 0, 3, 3);
    checkOutput("pre_load_idx", int'(idx), 0);
    applyStimulus(1, 1, 1, 1, 3, 1);
    checkOutput("scan_load_idx",  int'(idx),  1);
    checkOutput("scan_load_wrap", int'(wrap), 0);
    applyStimulus(1, 1, 0, 0, 3, 3);
    checkOutput("after_load_hold", int'(idx), 1);
    applyStimulus(1, 1, 0, 0, 3, 1);
    checkOutput("after_load_step", int'(idx), 2);

    // Enable gating in SCAN at idx 3.
    applyStimulus(1, 1, 3, 1, 3, 1);
    applyStimulus(0, 1, 0, 0, 3, 5);
    checkOutput("gate_out",  int'(out),  0);
    checkOutput("gate_busy", int'(busy), 0);
    checkOutput("gate_idx",  int'(idx),  3);
    applyStimulus(1, 1, 0, 0, 3, 1);
    checkOutput("regate_out",  int'(out),  'b1000);
    checkOutput("regate_busy", int'(busy), 1);
    applyStimulus(1, 1, 0, 0, 3, 3);
    checkOutput("regate_hold", int'(out), 'b1000);
    applyStimulus(1, 1, 0, 0, 3, 1);
    checkOutput("regate_step_out",  int'(out),  'b0001);
    checkOutput("regate_step_wrap", int'(wrap), 1);

    // dwell = 0 steps every cycle. Going to HOLD freezes idx.
    applyStimulus(1, 1, 0, 0, 0, 1);
    checkOutput("dwell0_idx", int'(idx), 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("freeze_idx", int'(idx), 1);
    applyStimulus(1, 0, 0, 0, 0, 3);
    checkOutput("freeze_hold_idx", int'(idx), 1);
    checkOutput("freeze_busy",     int'(busy), 0);

    // Lowering dwell below the running count forces an immediate step.
    applyStimulus(1, 1, 0, 0, 5, 1);
    applyStimulus(1, 1, 0, 0, 5, 4);
    checkOutput("pre_lower_idx", int'(idx), 1);
    applyStimulus(1, 1, 0, 0, 1, 1);
    checkOutput("lower_dwell_idx", int'(idx), 2);
`else
    // Without the scan feature, mode and dwell have no effect.
    applyStimulus(1, 1, 0, 0, 0, 16);
    checkOutput("noscan_idx",  int'(idx),  3);
    checkOutput("noscan_out",  int'(out),  'b1000);
    checkOutput("noscan_wrap", int'(wrap), 0);
    checkOutput("noscan_busy", int'(busy), 0);
`endif

    // Reset mid-operation without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out",  int'(out),  0);
    checkOutput("async_rst_idx",  int'(idx),  0);
    checkOutput("async_rst_wrap", int'(wrap), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    en = 1'b0;
    mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 2, 0, 0, 3);
    checkOutput("post_rst_out", int'(out), 0);
    applyStimulus(1, 0, 2, 0, 0, 1);
    checkOutput("post_rst_en_out", int'(out), 'b0001);

    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
